// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned NIBBLES   = WIDTH_DEF / NIBBLE_W;

  // Nibble count for an arbitrary operand width.
  function automatic int unsigned nibbles_of(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_rca.sv
// 4-bit ripple-carry adder built from explicit full-adder equations.
module RippleCarryAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit ripple adder reused over WIDTH/4
// cycles, with a valid/ready request side and a valid/ready result side.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NIB  = nibbles_of(WIDTH);
  localparam int unsigned IDXW = $clog2(NIB);
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             rv_q;
  logic             busy_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c_nib;

  assign a_nib = a_q[{idx, 2'b00} +: 4];
  assign b_nib = b_q[{idx, 2'b00} +: 4];

  RippleCarryAdder u_rca (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_nib),
    .cout (c_nib)
  );

  // busy_q tracks state != IDLE, so it doubles as the inverse of "in IDLE".
  assign start_ready  = ~busy_q & ~rst;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign overflow     = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      rv_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q    <= a;
            b_q    <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= s_nib;
          carry <= c_nib;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            // Flags are taken from the top nibble as it is written.
            cout_q <= c_nib;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s_nib[3] != a_q[WIDTH-1]);
            idx    <= '0;
            rv_q   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            rv_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          rv_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=32): vector table, scoreboard,
// backpressure, reset-abort and back-to-back sequences.
module tb_serial_add_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .sub          (sub),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb);
    res_t         r;
    logic [W-1:0] be;
    logic [W:0]   t;
    be     = sb ? ~bb : bb;
    t      = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (aa[W-1] == be[W-1]) && (t[W-1] != aa[W-1]);
    return r;
  endfunction

  // Scoreboard and latency bookkeeping
  res_t        sbq[$];
  int unsigned acc_q[$];
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;
  int unsigned b2b_n    = 0;
  bit          b2b      = 1'b0;
  logic        rv_prev  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbq.delete();
      acc_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (start_valid && start_ready) begin
        sbq.push_back(model(a, b, cin, sub));
        acc_q.push_back(cyc);
        if (b2b) begin
          if (b2b_n > 0) check("accept_spacing", 64'(cyc - last_acc), 64'(NIB + 2));
          last_acc <= cyc;
          b2b_n    <= b2b_n + 1;
        end
      end
    end
  end

  // Accept edge counts as cycle 1, so valid is seen NIB+1 edges after it.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid && !rv_prev) begin
        if (acc_q.size() == 0) check("latency_no_accept", 64'd1, 64'd0);
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'(NIB + 1));
      end
      if (result_valid && result_ready) begin
        if (sbq.size() == 0) check("sb_unexpected_result", 64'd1, 64'd0);
        else begin
          res_t r;
          r = sbq.pop_front();
          check("sb_sum", 64'(sum), 64'(r.sum));
          check("sb_cout", 64'(cout), 64'(r.cout));
          check("sb_ovf", 64'(overflow), 64'(r.ovf));
        end
      end
    end
    rv_prev <= result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, output res_t got);
    bit seen;
    start_valid = 1'b1;
    a   = ta;
    b   = tb;
    cin = tc;
    sub = ts;
    tick();
    start_valid = 1'b0;
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom);
    sub = 1'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    if (!seen) check("result_timeout", 64'd0, 64'd1);
    got.sum  = sum;
    got.cout = cout;
    got.ovf  = overflow;
  endtask

  vec_t vecs[10];
  res_t got;
  bit   any_rv;

  initial begin
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_1000, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vecs[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check("rst_start_ready", 64'(start_ready), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    #1;
    check("release_start_ready", 64'(start_ready), 64'd1);

    // Vector table
    result_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, got);
      check($sformatf("vec%0d_sum", i), 64'(got.sum), 64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(got.cout), 64'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 64'(got.ovf), 64'(vecs[i].ovf));
      tick();
      check($sformatf("vec%0d_idle_rv", i), 64'(result_valid), 64'd0);
      check($sformatf("vec%0d_idle_ready", i), 64'(start_ready), 64'd1);
      check($sformatf("vec%0d_hold_sum", i), 64'(sum), 64'(vecs[i].sum));
    end

    // Backpressure in DONE
    result_ready = 1'b0;
    run_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, got);
    check("bp_sum", 64'(got.sum), 64'h3333_3333);
    for (int i = 0; i < 5; i++) begin
      tick();
      start_valid = 1'b1;
      a = 32'hDEAD_0000 + 32'(i);
      b = 32'h0000_BEEF;
      @(negedge clk);
      check("bp_valid", 64'(result_valid), 64'd1);
      check("bp_start_ready", 64'(start_ready), 64'd0);
      check("bp_sum_stable", 64'(sum), 64'h3333_3333);
      check("bp_flags_stable", 64'({cout, overflow}), 64'd0);
    end
    tick();
    start_valid  = 1'b0;
    result_ready = 1'b1;
    tick();
    check("bp_release_rv", 64'(result_valid), 64'd0);
    check("bp_release_ready", 64'(start_ready), 64'd1);
    check("bp_release_sum", 64'(sum), 64'h3333_3333);

    // Reset while RUN is at nibble index 3
    start_valid = 1'b1;
    a = 32'h0F0F_0F0F;
    b = 32'h0101_0101;
    cin = 1'b0;
    sub = 1'b0;
    tick();
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_partial_sum", 64'(sum != '0), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rv", 64'(result_valid), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_flags", 64'({cout, overflow}), 64'd0);
    check("abort_start_ready", 64'(start_ready), 64'd0);
    tick();
    rst = 1'b0;
    any_rv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid) any_rv = 1'b1;
    end
    check("abort_no_result", 64'(any_rv), 64'd0);
    tick();
    run_op(32'd1, 32'd2, 1'b1, 1'b0, got);
    check("post_abort_sum", 64'(got.sum), 64'd4);
    tick();

    // Back-to-back with start_valid held high
    b2b = 1'b1;
    start_valid = 1'b1;
    for (int i = 0; i < 5 * (NIB + 2) + 3; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom);
      sub = 1'($urandom);
      tick();
    end
    start_valid = 1'b0;
    repeat (NIB + 4) tick();
    b2b = 1'b0;
    check("b2b_accept_count", 64'(b2b_n >= 5), 64'd1);
    check("b2b_sb_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  request carries a valid operand set.
REQ-005 start_ready  output  1  controller can accept a request.
REQ-006 a  input  WIDTH  operand A, sampled on accept.
REQ-007 b  input  WIDTH  operand B, sampled on accept.
REQ-008 cin  input  1  carry-in for add mode, sampled on accept.
REQ-009 sub  input  1  1 = compute A-B (cin ignored), 0 = compute A+B+cin; sampled on accept.
REQ-010 result_valid  output  1  sum/cout/overflow hold a completed result.
REQ-011 result_ready  input  1  consumer takes the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB nibble (in sub mode, 1 = no borrow).
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 start_ready SHALL be 1 exactly when state is IDLE; accept = start_valid & start_ready.
REQ-018 On accept: latch a, latch b (bitwise inverted when sub=1), set carry register to (sub ? 1 : cin), set nibble index to 0, clear sum register, go to RUN.
REQ-019 In RUN, each cycle SHALL apply nibble[index] of latched A and B plus the carry register to the 4-bit adder, write the 4-bit result into sum[4*index+3:4*index], load adder carry-out into the carry register, and increment index.
REQ-020 RUN SHALL last exactly WIDTH/4 cycles; on the cycle processing index WIDTH/4-1, the next state SHALL be DONE.
REQ-021 Latency: result_valid SHALL rise exactly WIDTH/4+1 cycles after the accept edge (9 cycles for WIDTH=32).
REQ-022 In DONE: result_valid=1; cout = final carry register; overflow = (A[MSB]==Beff[MSB]) & (sum[MSB]!=A[MSB]), where Beff is the latched (possibly inverted) B.
REQ-023 sum, cout, overflow SHALL stay stable while result_valid=1 and result_ready=0.
REQ-024 DONE with result_ready=1 SHALL return to IDLE next cycle; result_valid SHALL drop; sum/cout/overflow SHALL hold their values until the next accept.
REQ-025 start_valid in RUN or DONE SHALL be ignored (no accept, no operand capture); minimum request spacing is WIDTH/4+2 cycles.
REQ-026 result_ready outside DONE SHALL have no effect.
REQ-027 Wrap-around: carries out of the MSB SHALL appear only on cout; sum is modulo 2^WIDTH.
REQ-028 Operand inputs SHALL be don't-care except on the accept cycle.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, index=0, carry=0, sum=0, cout=0, overflow=0, result_valid=0, busy=0, start_ready=1 (after release).
REQ-030 rst asserted in RUN or DONE SHALL abort the operation; no result_valid SHALL follow release.
REQ-031 start_ready SHALL be 0 while rst=1.

Structure
REQ-032 State encoding (IDLE/RUN/DONE) and NIBBLES = WIDTH/4 SHALL be defined in a shared package serial_add_pkg.
REQ-033 The datapath SHALL be one instance of the team's existing 4-bit ripple-carry adder (RippleCarryAdder); no other arithmetic adder SHALL be inferred except the index incrementer.
REQ-034 Index register width SHALL be $clog2(NIBBLES).

Verification (WIDTH=32)
REQ-035 Add: a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> after 9 cycles sum=0x0000_0100, cout=0, overflow=0.
REQ-036 Wrap: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1, overflow=0; a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, overflow=1.
REQ-037 Sub: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0; a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, overflow=1, cout=1.
REQ-038 Backpressure: hold result_ready=0 for 5 cycles in DONE -> outputs stable, start_valid pulses ignored, start_ready=0; then result_ready=1 -> IDLE next cycle.
REQ-039 Reset mid-run: assert rst at RUN index 3 -> immediately IDLE, all outputs 0; after release a new request (a=1,b=2,cin=1) -> sum=4 after 9 cycles.
REQ-040 Back-to-back: start_valid held high continuously with distinct operands -> accepts spaced exactly 10 cycles, every result correct against a reference model.
